// File: rtl/rect_pulse_sequencer.sv
// Trapezoidal rectangular pulse sequencer: optional start delay, then repeating HI/LO
// phases with clamped ramps, for a programmed number of periods or until stopped.
module rect_pulse_sequencer #(
    parameter int W  = 12,
    parameter int TW = 16,
    parameter int NW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [W-1:0]  cfg_level,
    input  logic [W-1:0]  cfg_rise_step,
    input  logic [W-1:0]  cfg_fall_step,
    input  logic [TW-1:0] cfg_td,
    input  logic [TW-1:0] cfg_th,
    input  logic [TW-1:0] cfg_tl,
    input  logic [NW-1:0] cfg_nper,
    output logic [W-1:0]  out,
    output logic          busy,
    output logic [1:0]    phase,
    output logic          period_tick,
    output logic          done,
    output logic [NW-1:0] per_count
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_HI    = 2'd2,
        S_LO    = 2'd3
    } state_t;

    localparam logic [TW-1:0] T_ONE = TW'(1);
    localparam logic [NW-1:0] N_ONE = NW'(1);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [W-1:0]  out_q, out_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;
    logic [NW-1:0] per_q, per_d;
    logic [W-1:0]  level_q, level_d;
    logic [W-1:0]  rise_q, rise_d;
    logic [W-1:0]  fall_q, fall_d;
    logic [TW-1:0] th_m1_q, th_m1_d;
    logic [TW-1:0] tl_m1_q, tl_m1_d;
    logic [NW-1:0] nper_q, nper_d;

    logic [NW-1:0] per_inc;
    logic          fin;
    logic [TW-1:0] th_m1_in;
    logic [TW-1:0] tl_m1_in;

    // Rising ramp: W+1-bit sum so the clamp to the level cannot be fooled by overflow.
    function automatic logic [W-1:0] ramp_up(input logic [W-1:0] cur,
                                             input logic [W-1:0] step,
                                             input logic [W-1:0] lvl);
        logic [W:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        if (step == '0 || sum > {1'b0, lvl})
            return lvl;
        return sum[W-1:0];
    endfunction

    function automatic logic [W-1:0] ramp_dn(input logic [W-1:0] cur,
                                             input logic [W-1:0] step);
        if (step == '0 || cur <= step)
            return '0;
        return cur - step;
    endfunction

    assign per_inc  = per_q + N_ONE;
    assign fin      = (nper_q != '0) && (per_inc == nper_q);
    assign th_m1_in = (cfg_th == '0) ? '0 : cfg_th - T_ONE;
    assign tl_m1_in = (cfg_tl == '0) ? '0 : cfg_tl - T_ONE;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        out_d   = out_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        per_d   = per_q;
        level_d = level_q;
        rise_d  = rise_q;
        fall_d  = fall_q;
        th_m1_d = th_m1_q;
        tl_m1_d = tl_m1_q;
        nper_d  = nper_q;

        if (state_q == S_IDLE) begin
            out_d   = '0;
            timer_d = '0;
            if (start && !stop) begin
                level_d = cfg_level;
                rise_d  = cfg_rise_step;
                fall_d  = cfg_fall_step;
                th_m1_d = th_m1_in;
                tl_m1_d = tl_m1_in;
                nper_d  = cfg_nper;
                per_d   = '0;
                if (cfg_td != '0) begin
                    state_d = S_DELAY;
                    timer_d = cfg_td - T_ONE;
                end else begin
                    state_d = S_HI;
                    timer_d = th_m1_in;
                    out_d   = ramp_up('0, cfg_rise_step, cfg_level);
                end
            end
        end else if (stop) begin
            state_d = S_IDLE;
            timer_d = '0;
            out_d   = '0;
        end else begin
            case (state_q)
                S_DELAY: begin
                    if (timer_q == '0) begin
                        state_d = S_HI;
                        timer_d = th_m1_q;
                        out_d   = ramp_up(out_q, rise_q, level_q);
                    end else begin
                        timer_d = timer_q - T_ONE;
                    end
                end
                S_HI: begin
                    if (timer_q == '0) begin
                        state_d = S_LO;
                        timer_d = tl_m1_q;
                        out_d   = ramp_dn(out_q, fall_q);
                        // A one-cycle LO phase is its own last cycle.
                        if (tl_m1_q == '0) begin
                            tick_d = 1'b1;
                            done_d = fin;
                        end
                    end else begin
                        timer_d = timer_q - T_ONE;
                        out_d   = ramp_up(out_q, rise_q, level_q);
                    end
                end
                default: begin
                    if (timer_q == '0) begin
                        per_d = per_inc;
                        if (done_q) begin
                            state_d = S_IDLE;
                            timer_d = '0;
                            out_d   = '0;
                        end else begin
                            state_d = S_HI;
                            timer_d = th_m1_q;
                            out_d   = ramp_up(out_q, rise_q, level_q);
                        end
                    end else begin
                        timer_d = timer_q - T_ONE;
                        out_d   = ramp_dn(out_q, fall_q);
                        if (timer_q == T_ONE) begin
                            tick_d = 1'b1;
                            done_d = fin;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            out_q   <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            per_q   <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            th_m1_q <= '0;
            tl_m1_q <= '0;
            nper_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            out_q   <= out_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            per_q   <= per_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            th_m1_q <= th_m1_d;
            tl_m1_q <= tl_m1_d;
            nper_q  <= nper_d;
        end
    end

    assign out         = out_q;
    assign busy        = (state_q != S_IDLE);
    assign phase       = state_q;
    assign period_tick = tick_q;
    assign done        = done_q;
    assign per_count   = per_q;
endmodule

// File: tb/tb_rect_pulse_sequencer.sv
// Directed bench for rect_pulse_sequencer: per-cycle vector tables for the basic
// trapezoid and truncated-ramp cases, plus hand sequences for multi-period, stop and reset.
module tb_rect_pulse_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [11:0] cfg_level = '0;
    logic [11:0] cfg_rise_step = '0;
    logic [11:0] cfg_fall_step = '0;
    logic [15:0] cfg_td = '0;
    logic [15:0] cfg_th = '0;
    logic [15:0] cfg_tl = '0;
    logic [7:0]  cfg_nper = '0;
    logic [11:0] out;
    logic        busy;
    logic [1:0]  phase;
    logic        period_tick;
    logic        done;
    logic [7:0]  per_count;

    int total = 0;
    int bad = 0;

    rect_pulse_sequencer #(.W(12), .TW(16), .NW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_level(cfg_level), .cfg_rise_step(cfg_rise_step), .cfg_fall_step(cfg_fall_step),
        .cfg_td(cfg_td), .cfg_th(cfg_th), .cfg_tl(cfg_tl), .cfg_nper(cfg_nper),
        .out(out), .busy(busy), .phase(phase), .period_tick(period_tick),
        .done(done), .per_count(per_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cfg_id;
        logic        st;
        logic        sp;
        logic [11:0] e_out;
        logic [1:0]  e_ph;
        logic        e_tick;
        logic        e_done;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_cfg(input int lvl, input int r, input int f, input int td,
                           input int th, input int tl, input int np);
        cfg_level = 12'(lvl); cfg_rise_step = 12'(r); cfg_fall_step = 12'(f);
        cfg_td = 16'(td); cfg_th = 16'(th); cfg_tl = 16'(tl); cfg_nper = 8'(np);
    endtask

    task automatic apply_cfg(input int id);
        if (id == 0) set_cfg(100, 30, 50, 2, 6, 4, 1);
        else         set_cfg(100, 10, 0, 0, 3, 2, 0);
    endtask

    // Drive start/stop for one edge, then sample 1 time unit after it.
    task automatic step(input logic s, input logic p);
        start = s;
        stop  = p;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        int tick_c[$];
        int done_c;
        bit fin;
        bit done_seen;

        // cfg 0: td=2, six HI cycles ramping to 100, four LO cycles, one period
        vecs[0]  = '{0, 1'b1, 1'b0, 12'd0,   2'd1, 1'b0, 1'b0};
        vecs[1]  = '{0, 1'b0, 1'b0, 12'd0,   2'd1, 1'b0, 1'b0};
        vecs[2]  = '{0, 1'b0, 1'b0, 12'd30,  2'd2, 1'b0, 1'b0};
        vecs[3]  = '{0, 1'b0, 1'b0, 12'd60,  2'd2, 1'b0, 1'b0};
        vecs[4]  = '{0, 1'b0, 1'b0, 12'd90,  2'd2, 1'b0, 1'b0};
        vecs[5]  = '{0, 1'b0, 1'b0, 12'd100, 2'd2, 1'b0, 1'b0};
        vecs[6]  = '{0, 1'b0, 1'b0, 12'd100, 2'd2, 1'b0, 1'b0};
        vecs[7]  = '{0, 1'b0, 1'b0, 12'd100, 2'd2, 1'b0, 1'b0};
        vecs[8]  = '{0, 1'b0, 1'b0, 12'd50,  2'd3, 1'b0, 1'b0};
        vecs[9]  = '{0, 1'b0, 1'b0, 12'd0,   2'd3, 1'b0, 1'b0};
        vecs[10] = '{0, 1'b0, 1'b0, 12'd0,   2'd3, 1'b0, 1'b0};
        vecs[11] = '{0, 1'b0, 1'b0, 12'd0,   2'd3, 1'b1, 1'b1};
        vecs[12] = '{0, 1'b0, 1'b0, 12'd0,   2'd0, 1'b0, 1'b0};
        // cfg 1: truncated rise to 30, instant fall, free-running, then stopped
        vecs[13] = '{1, 1'b1, 1'b0, 12'd10,  2'd2, 1'b0, 1'b0};
        vecs[14] = '{1, 1'b0, 1'b0, 12'd20,  2'd2, 1'b0, 1'b0};
        vecs[15] = '{1, 1'b0, 1'b0, 12'd30,  2'd2, 1'b0, 1'b0};
        vecs[16] = '{1, 1'b0, 1'b0, 12'd0,   2'd3, 1'b0, 1'b0};
        vecs[17] = '{1, 1'b0, 1'b0, 12'd0,   2'd3, 1'b1, 1'b0};
        vecs[18] = '{1, 1'b0, 1'b0, 12'd10,  2'd2, 1'b0, 1'b0};
        vecs[19] = '{1, 1'b0, 1'b1, 12'd0,   2'd0, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", int'(out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_tick", int'(period_tick), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_per", int'(per_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Tables
        for (int i = 0; i < 20; i++) begin
            apply_cfg(vecs[i].cfg_id);
            step(vecs[i].st, vecs[i].sp);
            $display("vec %0d: out=%0d phase=%0d busy=%0d tick=%0d done=%0d per=%0d",
                     i, out, phase, busy, period_tick, done, per_count);
            chk($sformatf("v%0d_out", i), int'(out), int'(vecs[i].e_out));
            chk($sformatf("v%0d_phase", i), int'(phase), int'(vecs[i].e_ph));
            chk($sformatf("v%0d_busy", i), int'(busy), int'(vecs[i].e_ph != 2'd0));
            chk($sformatf("v%0d_tick", i), int'(period_tick), int'(vecs[i].e_tick));
            chk($sformatf("v%0d_done", i), int'(done), int'(vecs[i].e_done));
            if (i == 12) chk("t1_per", int'(per_count), 1);
        end
        chk("t3_per_after_stop", int'(per_count), 1);

        // Three periods, td=0
        set_cfg(100, 30, 50, 0, 6, 4, 3);
        step(1'b1, 1'b0);
        chk("t2_first_hi_out", int'(out), 30);
        chk("t2_first_hi_phase", int'(phase), 2);
        done_c = -1;
        fin = 1'b0;
        for (int c = 1; c <= 60 && !fin; c++) begin
            step(1'b0, 1'b0);
            if (period_tick) tick_c.push_back(c);
            if (done) done_c = c;
            if (phase == 2'd0) fin = 1'b1;
        end
        $display("t2: ticks=%0d done_at=%0d per=%0d", tick_c.size(), done_c, per_count);
        chk("t2_finished", int'(fin), 1);
        chk("t2_ntick", tick_c.size(), 3);
        if (tick_c.size() == 3) begin
            chk("t2_tick0", tick_c[0], 9);
            chk("t2_gap1", tick_c[1] - tick_c[0], 10);
            chk("t2_gap2", tick_c[2] - tick_c[1], 10);
            chk("t2_done_with_tick3", done_c, tick_c[2]);
        end
        chk("t2_per", int'(per_count), 3);

        // Free-run, stop in the 4th period's HI
        set_cfg(100, 30, 50, 0, 6, 4, 0);
        step(1'b1, 1'b0);
        done_seen = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            step(1'b0, 1'b0);
            if (done) done_seen = 1'b1;
        end
        chk("t4_pre_phase", int'(phase), 2);
        chk("t4_pre_per", int'(per_count), 3);
        step(1'b0, 1'b1);
        $display("t4: after stop out=%0d phase=%0d busy=%0d per=%0d", out, phase, busy, per_count);
        chk("t4_out", int'(out), 0);
        chk("t4_phase", int'(phase), 0);
        chk("t4_busy", int'(busy), 0);
        chk("t4_per", int'(per_count), 3);
        chk("t4_no_done", int'(done_seen | done), 0);
        chk("t4_no_tick", int'(period_tick), 0);

        // Start mid-HI with a new level is ignored
        apply_cfg(0);
        step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        cfg_level = 12'd500;
        step(1'b1, 1'b0);
        chk("t5_restart_out", int'(out), 90);
        step(1'b0, 1'b0);
        chk("t5_level_kept", int'(out), 100);
        fin = 1'b0;
        for (int c = 0; c < 20 && !fin; c++) begin
            step(1'b0, 1'b0);
            if (phase == 2'd0) fin = 1'b1;
        end
        chk("t5_finished", int'(fin), 1);
        chk("t5_per", int'(per_count), 1);
        cfg_level = 12'd100;
        step(1'b1, 1'b1);
        $display("t5: start+stop from idle phase=%0d busy=%0d", phase, busy);
        chk("t5_ss_phase", int'(phase), 0);
        chk("t5_ss_busy", int'(busy), 0);
        step(1'b0, 1'b1);
        chk("t5_stop_idle", int'(phase), 0);

        // Asynchronous reset mid-LO
        apply_cfg(0);
        step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0);
        chk("t6_in_lo", int'(phase), 3);
        chk("t6_lo_out", int'(out), 50);
        #3;
        rst_n = 1'b0;
        #1;
        $display("t6: async reset out=%0d phase=%0d busy=%0d", out, phase, busy);
        chk("t6_out", int'(out), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_phase", int'(phase), 0);
        chk("t6_per", int'(per_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        chk("t6_rerun_out", int'(out), 30);
        chk("t6_rerun_phase", int'(phase), 2);
        done_seen = 1'b0;
        for (int c = 0; c < 20 && phase != 2'd0; c++) begin
            step(1'b0, 1'b0);
            if (done) done_seen = 1'b1;
        end
        chk("t6_rerun_done", int'(done_seen), 1);
        chk("t6_rerun_per", int'(per_count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
